// File: rtl/dcache_refill_row_writer.sv
// dcache_refill_row_writer: pairs 64-bit refill beats into 128-bit data-array row writes for one cache line.
//   clock/reset          : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  : line refill request; way/idx captured on handshake
//   beat_valid/ready/data: grant-path refill beats, even = row low half, odd = row high half
//   wr_valid/ready/...   : full-row write to the arbiter low-priority port
//   done                 : one-cycle pulse after the last row write is accepted
//   busy                 : high whenever a refill is in progress
module dcache_refill_row_writer #(
   parameter int BEAT_W        = 64,
   parameter int ROWS_PER_LINE = 4,
   parameter int WAYS          = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [WAYS-1:0]     req_way_en,
   input  logic [5:0]          req_idx,
   input  logic                beat_valid,
   output logic                beat_ready,
   input  logic [BEAT_W-1:0]   beat_data,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [WAYS-1:0]     wr_way_en,
   output logic [11:0]         wr_addr,
   output logic [2*BEAT_W-1:0] wr_data,
   output logic                done,
   output logic                busy
);
   localparam logic [2:0] LAST_BEAT = 3'(2*ROWS_PER_LINE-1);
   localparam logic [1:0] LAST_ROW  = 2'(ROWS_PER_LINE-1);
   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
   state_t              state;
   logic [2:0]          beat_cnt;
   logic [1:0]          row_cnt;
   logic [BEAT_W-1:0]   lo;
   logic                lo_v;
   logic [2*BEAT_W-1:0] fifo [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          occ;
   logic [WAYS-1:0]     way;
   logic [5:0]          idx;
   logic                beat_hs;
   logic                push;
   logic                pop;
   assign req_ready  = state == IDLE;
   assign busy       = state != IDLE;
   // A high half can only be taken when there is room to push the completed row;
   // a low half always fits in the half register.
   assign beat_ready = state == FILL && (!lo_v || occ != 2'd2);
   assign beat_hs    = beat_valid && beat_ready;
   assign push       = beat_hs && beat_cnt[0];
   assign wr_valid   = occ != 2'd0;
   assign pop        = wr_valid && wr_ready;
   assign wr_way_en  = way;
   assign wr_addr    = {idx, row_cnt, 4'h0};
   assign wr_data    = fifo[rd_ptr];
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         row_cnt  <= '0;
         lo       <= '0;
         lo_v     <= 1'b0;
         fifo[0]  <= '0;
         fifo[1]  <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         occ      <= '0;
         way      <= '0;
         idx      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (req_valid) begin
               state    <= FILL;
               way      <= req_way_en;
               idx      <= req_idx;
               beat_cnt <= '0;
               row_cnt  <= '0;
               lo_v     <= 1'b0;
               wr_ptr   <= 1'b0;
               rd_ptr   <= 1'b0;
               occ      <= '0;
            end
         end else begin
            if (beat_hs) begin
               beat_cnt <= beat_cnt + 3'd1;
               if (beat_cnt == LAST_BEAT) state <= DRAIN;
               if (!beat_cnt[0]) begin
                  lo   <= beat_data;
                  lo_v <= 1'b1;
               end else begin
                  fifo[wr_ptr] <= {beat_data, lo};
                  wr_ptr       <= ~wr_ptr;
                  lo_v         <= 1'b0;
               end
            end
            if (pop) begin
               rd_ptr  <= ~rd_ptr;
               row_cnt <= row_cnt + 2'd1;
               // The last row can only be popped after the last beat, i.e. in DRAIN.
               if (row_cnt == LAST_ROW) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
         end
      end
   end
endmodule
